// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with architectural HI/LO registers.
// One shift-add or shift-subtract step per cycle; sign fix-up and register write happen in a final cycle.
`timescale 1ns/1ps
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_next;
  logic [1:0]  op_q;
  logic [31:0] a_mag, b_mag, a_raw;
  logic        res_neg, rem_neg, div_zero;
  logic [5:0]  cnt;
  logic [63:0] acc;

  logic        accept;
  logic        a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum;
  logic [33:0] div_diff;
  logic [63:0] acc_step, prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == 6'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept = (state == IDLE) && start;
    a_neg  = ~op[0] & src_a[31];
    b_neg  = ~op[0] & src_b[31];
    a_abs  = a_neg ? -src_a : src_a;
    b_abs  = b_neg ? -src_b : src_b;

    // Multiply: {partial product, remaining multiplier bits}, shifted right each step.
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
    // Divide: {partial remainder, remaining dividend / quotient bits}, shifted left each step.
    div_diff = {1'b0, acc[63:31]} - {2'b0, b_mag};

    acc_step = {mul_sum, acc[31:1]};
    if (op_q[1]) begin
      if (!div_diff[33]) acc_step = {div_diff[31:0], acc[30:0], 1'b1};
      else               acc_step = {acc[62:31], acc[30:0], 1'b0};
    end

    prod_fix = res_neg ? -acc : acc;
    quo_fix  = res_neg ? -acc[31:0]  : acc[31:0];
    rem_fix  = rem_neg ? -acc[63:32] : acc[63:32];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= 2'b00;
      a_mag    <= '0;
      b_mag    <= '0;
      a_raw    <= '0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == FIX);

      if (accept) begin
        op_q     <= op;
        a_mag    <= a_abs;
        b_mag    <= b_abs;
        a_raw    <= src_a;
        res_neg  <= a_neg ^ b_neg;
        rem_neg  <= a_neg;
        div_zero <= (src_b == 32'd0);
        cnt      <= '0;
        acc      <= op[1] ? {32'd0, a_abs} : {32'd0, b_abs};
      end else if (state == CALC) begin
        cnt <= cnt + 6'd1;
        acc <= acc_step;
      end

      if (state == FIX) begin
        if (!op_q[1]) begin
          hi <= op_q[0] ? acc[63:32] : prod_fix[63:32];
          lo <= op_q[0] ? acc[31:0]  : prod_fix[31:0];
        end else if (div_zero) begin
          hi <= a_raw;
          lo <= 32'hFFFF_FFFF;
        end else begin
          hi <= op_q[0] ? acc[63:32] : rem_fix;
          lo <= op_q[0] ? acc[31:0]  : quo_fix;
        end
      end else if (state == IDLE && !start) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS32 core. It executes MULT, MULTU, DIV and DIVU over a fixed multi-cycle sequence and services MTHI/MTLO writes. Its `hi` and `lo` outputs feed the write-back select multiplexer directly, as the MFHI/MFLO sources. `busy` drives the pipeline stall logic.

## Interface
- No parameters; datapath width fixed at 32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begin an operation; sampled only in IDLE.
- `op` input 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `src_a` input 32: rs operand (multiplicand / dividend).
- `src_b` input 32: rt operand (multiplier / divisor).
- `hi_we` input 1: MTHI write enable.
- `lo_we` input 1: MTLO write enable.
- `wdata` input 32: MTHI/MTLO data.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse; HI/LO hold the new result.
- `hi` output 32: HI register (remainder, or product[63:32]).
- `lo` output 32: LO register (quotient, or product[31:0]).

## Operation
- States: IDLE, CALC, FIX.
- IDLE → CALC when `start`=1:
  - Latch `op`.
  - Latch the operand magnitudes: absolute value for signed ops, raw value for unsigned ops.
  - Latch the result-sign flags.
  - Clear the 6-bit iteration counter.
- CALC runs 32 iterations, one per cycle; counter wraps 31 → FIX.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
- FIX → IDLE. Applies sign correction and writes both `hi` and `lo`.
  - MULT: 64-bit product negated if operand signs differ.
  - DIV: quotient negated if signs differ; remainder takes the sign of the dividend.
  - Unsigned ops: no correction.
- Divide by zero (`src_b`=0), both DIV and DIVU: `lo`=0xFFFFFFFF, `hi`=`src_a` as originally presented; no sign correction.
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0. This is the natural wrap; no special flag.
- MTHI/MTLO (only in IDLE with `start`=0): `hi_we` loads `hi`, `lo_we` loads `lo`. Both may assert in the same cycle and load the same `wdata`.
- Ignored events:
  - `start` while busy.
  - `hi_we`/`lo_we` while busy, or in the same cycle as an accepted `start`. These writes are dropped.
- `hi`/`lo` hold their previous values throughout CALC; they change only in FIX or on MTHI/MTLO.

## Timing
- Reset value of all outputs is 0: `hi`, `lo`, `busy`, `done`. State returns to IDLE and the counter clears.
- Reset asserted mid-operation aborts immediately and clears `hi`/`lo`. No `done` is produced.
- `start` accepted at edge E0. CALC iterations occur at edges E1..E32. FIX writes `hi`/`lo` at E33.
- `busy` is registered: high from after E0 through E33 (33 cycles). It is low in the cycle after E33.
- `done` is registered: high exactly the one cycle after E33, together with the new `hi`/`lo`. It is low otherwise.
- Back-to-back: a new `start` may be accepted at E34, i.e. during the `done` cycle.
- Total latency from `start` edge to result visible: 34 cycles.
- MTHI/MTLO write latency: 1 cycle. The value is visible on `hi`/`lo` after the accepting edge.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` pulses in the 34th cycle after the `start` edge; `busy` is high for exactly 33 cycles.
- MULT with inputs 0xFFFFFFFD (−3) and 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- DIV with inputs 0xFFFFFFF9 (−7) and 2:
  - `lo`=0xFFFFFFFD.
  - `hi`=0xFFFFFFFF.
- DIVU 100 / 0 → `lo`=0xFFFFFFFF, `hi`=0x00000064.
- Ignored writes and starts:
  - MTHI 0x12345678 in IDLE → `hi`=0x12345678 next cycle, `lo` unchanged.
  - During an active DIVU 10/3, pulse `hi_we`, `lo_we` and a second `start`. Required result: no effect; final `hi`=1, `lo`=3; exactly one `done` pulse.
- Reset mid-CALC, at iteration 10 of a MULTU → `hi`=`lo`=0, `busy`=0, no `done`. A fresh MULTU 6×7 then yields `lo`=42, `hi`=0.
